// File: rtl/stash_scanner.sv
// Browses a circular sample stash one slot at a time, either by button or on a tick-based dwell
// timer, and holds a registered copy of the displayed sample.
module stash_scanner #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     browse_btn_i,
  input  logic                     auto_en_i,
  input  logic                     tick_i,
  input  logic [WIDTH-1:0]         sample_out_i,
  output logic                     next_sample_o,
  output logic [$clog2(DEPTH)-1:0] index_o,
  output logic [WIDTH-1:0]         display_value_o,
  output logic                     display_valid_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
  localparam logic [7:0] DwellLast = 8'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StShow, StStep} state_e;

  state_e            state_q;
  logic [7:0]        dwell_q;
  logic              next_q;
  logic [IdxW-1:0]   index_q;
  logic [WIDTH-1:0]  value_q;
  logic              valid_q;
  logic              step_req;

  // A button press and a dwell expiry in the same cycle collapse into one request.
  assign step_req = browse_btn_i | (auto_en_i & tick_i & (dwell_q == DwellLast));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      dwell_q <= '0;
      next_q  <= 1'b0;
      index_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      next_q <= 1'b0;
      if (!auto_en_i) begin
        dwell_q <= '0;
      end
      unique case (state_q)
        StIdle: begin
          if (enable_i) begin
            state_q <= StSettle;
          end
        end
        StSettle: begin
          value_q <= sample_out_i;
          valid_q <= 1'b1;
          state_q <= StShow;
        end
        StShow: begin
          if (!enable_i) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end else if (step_req) begin
            next_q  <= 1'b1;
            state_q <= StStep;
          end else if (auto_en_i && tick_i) begin
            dwell_q <= dwell_q + 8'd1;
          end
        end
        StStep: begin
          index_q <= (index_q == LastIdx) ? '0 : index_q + 1'b1;
          dwell_q <= '0;
          state_q <= StSettle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign next_sample_o   = next_q;
  assign index_o         = index_q;
  assign display_value_o = value_q;
  assign display_valid_o = valid_q;

endmodule
